// File: rtl/debug_unit_ctrl_pkg.sv
// Shared constants, state encodings and types for the MIPS debug-port controller.
package debug_unit_ctrl_pkg;

  localparam int NB_IF_ID  = 64;
  localparam int NB_ID_EX  = 139;
  localparam int NB_EX_MEM = 76;
  localparam int NB_MEM_WB = 71;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [7:0] FRM_HDR = 8'hA5;
  localparam logic [7:0] FRM_TRL = 8'h5A;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } tx_byte_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_CNT,
    ST_LOAD_DATA,
    ST_ACK,
    ST_RESP,
    ST_RUN,
    ST_DRAIN,
    ST_STEP,
    ST_DUMP
  } ctrl_state_e;

  typedef enum logic [2:0] {
    SR_IDLE,
    SR_HDR,
    SR_SNAP,
    SR_ADDR,
    SR_CAP,
    SR_WORD,
    SR_TRL
  } ser_state_e;

  function automatic int bytes_for_bits(input int nbits);
    return (nbits + 7) / 8;
  endfunction

endpackage

// File: rtl/debug_unit_ctrl_dump_serializer.sv
// Emits one dump frame: header, latch snapshot, register file, data memory, trailer.
module dump_serializer
  import debug_unit_ctrl_pkg::*;
#(
  parameter int NB_SNAP     = 350,
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_SNAP-1:0] i_snap,
  output tx_byte_t           o_tx,
  input  logic               i_tx_ready,
  output logic [4:0]         o_r_addr_registers,
  output logic [4:0]         o_r_addr_data_mem,
  input  logic [31:0]        i_r_data_registers,
  input  logic [31:0]        i_r_data_data_mem,
  output logic               o_done
);

  localparam int SNAP_BYTES = bytes_for_bits(NB_SNAP);
  localparam int SNAP_W     = SNAP_BYTES * 8;
  localparam int PAD        = SNAP_W - NB_SNAP;
  localparam int CW         = (SNAP_BYTES > 4) ? $clog2(SNAP_BYTES) : 2;

  ser_state_e        st;
  logic [SNAP_W-1:0] snap;
  logic [31:0]       word_sr;
  logic [CW-1:0]     byte_cnt;
  logic              sel_mem;
  logic [4:0]        idx;
  logic              accept;
  logic [31:0]       rdata;

  assign accept = o_tx.valid & i_tx_ready;
  assign rdata  = sel_mem ? i_r_data_data_mem : i_r_data_registers;

  // Only the active region sees the running index; the idle one sits at 0.
  assign o_r_addr_registers = sel_mem ? 5'd0 : idx;
  assign o_r_addr_data_mem  = sel_mem ? idx : 5'd0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      st       <= SR_IDLE;
      snap     <= '0;
      word_sr  <= '0;
      byte_cnt <= '0;
      sel_mem  <= 1'b0;
      idx      <= '0;
      o_tx     <= '0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (st)
        SR_IDLE: if (i_start) begin
          // Snapshot is left-justified so the zero padding lands at the LSB end.
          snap    <= SNAP_W'(i_snap) << PAD;
          sel_mem <= 1'b0;
          idx     <= '0;
          o_tx    <= '{valid: 1'b1, data: FRM_HDR};
          st      <= SR_HDR;
        end
        SR_HDR: if (accept) begin
          o_tx.data <= snap[SNAP_W-1 -: 8];
          snap      <= snap << 8;
          byte_cnt  <= '0;
          st        <= SR_SNAP;
        end
        SR_SNAP: if (accept) begin
          if (byte_cnt == CW'(SNAP_BYTES - 1)) begin
            o_tx.valid <= 1'b0;
            st         <= SR_ADDR;
          end else begin
            o_tx.data <= snap[SNAP_W-1 -: 8];
            snap      <= snap << 8;
            byte_cnt  <= byte_cnt + 1'b1;
          end
        end
        SR_ADDR: st <= SR_CAP;
        SR_CAP: begin
          word_sr  <= {rdata[23:0], 8'h00};
          o_tx     <= '{valid: 1'b1, data: rdata[31:24]};
          byte_cnt <= '0;
          st       <= SR_WORD;
        end
        SR_WORD: if (accept) begin
          if (byte_cnt == CW'(3)) begin
            if (sel_mem && idx == 5'(N_MEM_WORDS - 1)) begin
              o_tx.data <= FRM_TRL;
              st        <= SR_TRL;
            end else begin
              o_tx.valid <= 1'b0;
              st         <= SR_ADDR;
              if (!sel_mem && idx == 5'(N_REGS - 1)) begin
                sel_mem <= 1'b1;
                idx     <= '0;
              end else begin
                idx <= idx + 5'd1;
              end
            end
          end else begin
            o_tx.data <= word_sr[31:24];
            word_sr   <= word_sr << 8;
            byte_cnt  <= byte_cnt + 1'b1;
          end
        end
        SR_TRL: if (accept) begin
          o_tx.valid <= 1'b0;
          sel_mem    <= 1'b0;
          idx        <= '0;
          o_done     <= 1'b1;
          st         <= SR_IDLE;
        end
        default: st <= SR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/debug_unit_ctrl.sv
// Debug-port sequencer: decodes host commands, loads imem, runs/steps the pipeline, dumps state.
module debug_unit_ctrl #(
  parameter int NB_IF_ID     = debug_unit_ctrl_pkg::NB_IF_ID,
  parameter int NB_ID_EX     = debug_unit_ctrl_pkg::NB_ID_EX,
  parameter int NB_EX_MEM    = debug_unit_ctrl_pkg::NB_EX_MEM,
  parameter int NB_MEM_WB    = debug_unit_ctrl_pkg::NB_MEM_WB,
  parameter int N_REGS       = 32,
  parameter int N_MEM_WORDS  = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_halt,
  output logic                 o_write_instruction_mem,
  output logic [31:0]          o_instruction_mem_addr,
  output logic [31:0]          o_instruction_mem_data,
  output logic [4:0]           o_r_addr_registers,
  output logic [4:0]           o_r_addr_data_mem,
  input  logic [31:0]          i_r_data_registers,
  input  logic [31:0]          i_r_data_data_mem,
  input  logic [NB_IF_ID-1:0]  i_IF_ID,
  input  logic [NB_ID_EX-1:0]  i_ID_EX,
  input  logic [NB_EX_MEM-1:0] i_EX_MEM,
  input  logic [NB_MEM_WB-1:0] i_MEM_WB,
  input  logic                 i_end
);
  import debug_unit_ctrl_pkg::*;

  localparam int NB_SNAP = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
  localparam int DCW     = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_state_e    state;
  logic [8:0]     n_words;
  logic [8:0]     k;
  logic [1:0]     byte_idx;
  logic [23:0]    word_acc;
  logic [DCW-1:0] drain_cnt;
  logic           ser_start;
  logic           ser_done;
  tx_byte_t       resp;
  tx_byte_t       ser_tx;

  // Responses and dump frames are never in flight together, so a simple OR/mux suffices.
  assign o_tx_valid = ser_tx.valid | resp.valid;
  assign o_tx_data  = ser_tx.valid ? ser_tx.data : resp.data;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state                   <= ST_IDLE;
      o_halt                  <= 1'b1;
      o_write_instruction_mem <= 1'b0;
      o_instruction_mem_addr  <= '0;
      o_instruction_mem_data  <= '0;
      n_words                 <= '0;
      k                       <= '0;
      byte_idx                <= '0;
      word_acc                <= '0;
      drain_cnt               <= '0;
      ser_start               <= 1'b0;
      resp                    <= '0;
    end else begin
      o_write_instruction_mem <= 1'b0;
      ser_start               <= 1'b0;
      case (state)
        ST_IDLE: if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: state <= ST_LOAD_CNT;
            CMD_CONT: begin
              o_halt <= 1'b0;
              state  <= ST_RUN;
            end
            CMD_STEP: begin
              o_halt <= 1'b0;
              state  <= ST_STEP;
            end
            default: begin
              resp  <= '{valid: 1'b1, data: RSP_NAK};
              state <= ST_RESP;
            end
          endcase
        end
        ST_LOAD_CNT: if (i_rx_valid) begin
          n_words  <= (i_rx_data == 8'h00) ? 9'd256 : {1'b0, i_rx_data};
          k        <= '0;
          byte_idx <= '0;
          state    <= ST_LOAD_DATA;
        end
        ST_LOAD_DATA: if (i_rx_valid) begin
          if (byte_idx == 2'd3) begin
            o_write_instruction_mem <= 1'b1;
            o_instruction_mem_addr  <= 32'({k, 2'b00});
            o_instruction_mem_data  <= {word_acc, i_rx_data};
            k                       <= k + 9'd1;
            byte_idx                <= '0;
            if (k + 9'd1 == n_words) state <= ST_ACK;
          end else begin
            word_acc <= {word_acc[15:0], i_rx_data};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        ST_ACK: begin
          resp  <= '{valid: 1'b1, data: RSP_ACK};
          state <= ST_RESP;
        end
        ST_RESP: if (resp.valid && i_tx_ready) begin
          resp.valid <= 1'b0;
          state      <= ST_IDLE;
        end
        ST_RUN: if (i_end) begin
          if (DRAIN_CYCLES == 0) begin
            o_halt    <= 1'b1;
            ser_start <= 1'b1;
            state     <= ST_DUMP;
          end else begin
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DCW'(DRAIN_CYCLES - 1)) begin
            o_halt    <= 1'b1;
            ser_start <= 1'b1;
            state     <= ST_DUMP;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_STEP: begin
          o_halt    <= 1'b1;
          ser_start <= 1'b1;
          state     <= ST_DUMP;
        end
        ST_DUMP: if (ser_done) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Snapshot is taken the cycle after halt rises, so the latches are already frozen.
  dump_serializer #(
    .NB_SNAP     (NB_SNAP),
    .N_REGS      (N_REGS),
    .N_MEM_WORDS (N_MEM_WORDS)
  ) u_ser (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_start            (ser_start),
    .i_snap             ({i_IF_ID, i_ID_EX, i_EX_MEM, i_MEM_WB}),
    .o_tx               (ser_tx),
    .i_tx_ready         (i_tx_ready),
    .o_r_addr_registers (o_r_addr_registers),
    .o_r_addr_data_mem  (o_r_addr_data_mem),
    .i_r_data_registers (i_r_data_registers),
    .i_r_data_data_mem  (i_r_data_data_mem),
    .o_done             (ser_done)
  );

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Directed bench for debug_unit_ctrl: load, step, run, TX stall, NAK and reset abort.
module tb_debug_unit_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         halt;
  logic         wr;
  logic [31:0]  waddr, wdata;
  logic [4:0]   ra_reg, ra_mem;
  logic [31:0]  rd_reg, rd_mem;
  logic [63:0]  if_id;
  logic [138:0] id_ex;
  logic [75:0]  ex_mem;
  logic [70:0]  mem_wb;
  logic         pend;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  // Register file and data memory models.
  assign rd_reg = 32'h100 + {27'b0, ra_reg};
  assign rd_mem = 32'h200 + {27'b0, ra_mem};

  debug_unit_ctrl dut (
    .i_clk                   (clk),
    .i_reset                 (rst_n),
    .i_rx_data               (rx_data),
    .i_rx_valid              (rx_valid),
    .o_tx_data               (tx_data),
    .o_tx_valid              (tx_valid),
    .i_tx_ready              (tx_ready),
    .o_halt                  (halt),
    .o_write_instruction_mem (wr),
    .o_instruction_mem_addr  (waddr),
    .o_instruction_mem_data  (wdata),
    .o_r_addr_registers      (ra_reg),
    .o_r_addr_data_mem       (ra_mem),
    .i_r_data_registers      (rd_reg),
    .i_r_data_data_mem       (rd_mem),
    .i_IF_ID                 (if_id),
    .i_ID_EX                 (id_ex),
    .i_EX_MEM                (ex_mem),
    .i_MEM_WB                (mem_wb),
    .i_end                   (pend)
  );

  // Inputs change at posedge+2, so negedge values are what the next posedge consumes.
  logic [7:0]  txq[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          hlow = 0;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (rst_n && !halt) hlow++;
    if (rst_n && wr) begin
      wa.push_back(waddr);
      wd.push_back(wdata);
    end
  end

  logic [7:0] exp_frame [302];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #2;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #2;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && txq.size() < n; i++) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int base);
    int mism;
    mism = 0;
    wait_tx(base + 302, 3000);
    repeat (20) @(negedge clk);
    chk({tag, "_len"}, 64'(txq.size() - base), 302);
    for (int i = 0; i < 302; i++) begin
      if (base + i >= txq.size()) mism++;
      else if (txq[base + i] !== exp_frame[i]) mism++;
    end
    chk({tag, "_bytes"}, 64'(mism), 0);
  endtask

  initial begin
    logic [351:0] snap_exp;
    logic [31:0]  w;
    int           base;
    int           h0;
    int           w0;
    logic [7:0]   d0;
    logic         stable;

    if_id  = 64'h0123_4567_89AB_CDEF;
    id_ex  = {11'h5AB, {4{32'hDEADBEEF}}};
    ex_mem = {12'hC3C, 64'h0F1E_2D3C_4B5A_6978};
    mem_wb = {7'h55, 64'h0000_0000_0000_003F};

    snap_exp = {if_id, id_ex, ex_mem, mem_wb, 2'b00};
    exp_frame[0] = 8'hA5;
    for (int i = 0; i < 44; i++) exp_frame[1 + i] = snap_exp[351 - 8*i -: 8];
    for (int r = 0; r < 32; r++) begin
      w = 32'h100 + r;
      for (int j = 0; j < 4; j++) exp_frame[45 + 4*r + j] = w[31 - 8*j -: 8];
      w = 32'h200 + r;
      for (int j = 0; j < 4; j++) exp_frame[173 + 4*r + j] = w[31 - 8*j -: 8];
    end
    exp_frame[301] = 8'h5A;

    rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1; pend = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_halt", halt, 1);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_wr", wr, 0);
    chk("rst_addr", waddr, 0);
    chk("rst_data", wdata, 0);
    chk("rst_raddr", {ra_reg, ra_mem}, 0);
    #1 rst_n = 1'b1;

    // Program load of two words.
    base = txq.size(); h0 = hlow;
    send_rx(8'h4C); send_rx(8'h02);
    send_rx(8'h20); send_rx(8'hA6); send_rx(8'h00); send_rx(8'h04);
    send_rx(8'hFF); send_rx(8'hFF); send_rx(8'hFF); send_rx(8'hFF);
    wait_tx(base + 1, 50);
    repeat (10) @(negedge clk);
    chk("load_wr_cnt", 64'(wa.size()), 2);
    if (wa.size() == 2) begin
      chk("load_a0", wa[0], 32'h0);
      chk("load_d0", wd[0], 32'h20A60004);
      chk("load_a1", wa[1], 32'h4);
      chk("load_d1", wd[1], 32'hFFFFFFFF);
    end
    chk("load_tx_cnt", 64'(txq.size() - base), 1);
    chk("load_ack", txq[base], 8'h06);
    chk("load_halt", 64'(hlow - h0), 0);

    // Single step and full dump frame.
    base = txq.size(); h0 = hlow;
    send_rx(8'h53);
    check_frame("step", base);
    chk("step_halt_low", 64'(hlow - h0), 1);
    chk("step_hdr", txq[base], 8'hA5);
    chk("step_snap0", txq[base + 1], 8'h01);
    chk("step_snap43", txq[base + 44], 8'hFC);
    chk("step_r0", {txq[base+45], txq[base+46], txq[base+47], txq[base+48]}, 32'h00000100);
    chk("step_trl", txq[base + 301], 8'h5A);
    chk("step_raddr", {ra_reg, ra_mem}, 0);
    chk("step_halt_end", halt, 1);

    // Continuous run: i_end raised 10 cycles after the command.
    // halt low after the command edge through the third cycle after i_end is sampled: 11+3.
    base = txq.size(); h0 = hlow;
    send_rx(8'h43);
    repeat (10) @(posedge clk);
    #2 pend = 1'b1;
    check_frame("run", base);
    chk("run_halt_low", 64'(hlow - h0), 14);
    pend = 1'b0;

    // TX stall mid-dump plus an ignored 'C'.
    base = txq.size(); h0 = hlow;
    send_rx(8'h53);
    wait_tx(base + 100, 1000);
    @(posedge clk); #2 tx_ready = 1'b0;
    for (int i = 0; i < 10 && !tx_valid; i++) @(negedge clk);
    @(negedge clk);
    d0 = tx_data; stable = tx_valid;
    repeat (5) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== d0) stable = 1'b0;
    end
    chk("stall_stable", stable, 1);
    @(posedge clk); #2 tx_ready = 1'b1;
    send_rx(8'h43);
    check_frame("stall", base);
    chk("stall_halt_low", 64'(hlow - h0), 1);

    // Asynchronous reset while running.
    send_rx(8'h43);
    repeat (2) @(posedge clk);
    chk("run_pre_rst", halt, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_halt", halt, 1);
    chk("async_txv", tx_valid, 0);
    chk("async_wr", wr, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Unknown command.
    base = txq.size();
    send_rx(8'h58);
    repeat (10) @(negedge clk);
    chk("nak_cnt", 64'(txq.size() - base), 1);
    chk("nak_byte", txq[base], 8'h15);

    // Partial load aborted by reset.
    base = txq.size(); w0 = wa.size();
    send_rx(8'h4C); send_rx(8'h01); send_rx(8'hAA); send_rx(8'hBB);
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    send_rx(8'hCC); send_rx(8'hDD);
    repeat (10) @(negedge clk);
    chk("abort_wr", 64'(wa.size() - w0), 0);
    chk("abort_tx", 64'(txq.size() - base), 2);
    if (txq.size() == base + 2) begin
      chk("abort_nak0", txq[base], 8'h15);
      chk("abort_nak1", txq[base + 1], 8'h15);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/debug_unit_ctrl.md
Name: debug_unit_ctrl

Overview:
Host-side controller that sequences the MIPS pipeline through its debug port. It decodes commands from a byte stream (UART RX side) and acts on them:
- loads a program into instruction memory;
- runs the pipeline continuously or single-steps it by driving halt;
- after each run or step, streams a dump frame over a byte TX handshake: latch snapshot, register file, data memory.

It sits between the UART and the pipeline top, and is the only agent driving the pipeline's halt and instruction-write inputs.

Parameters:
NB_IF_ID, 64, IF/ID latch width
NB_ID_EX, 139, ID/EX latch width
NB_EX_MEM, 76, EX/MEM latch width
NB_MEM_WB, 71, MEM/WB latch width
N_REGS, 32, registers dumped
N_MEM_WORDS, 32, data-memory words dumped (indices 0..N_MEM_WORDS-1)
DRAIN_CYCLES, 3, extra run cycles after i_end before halting

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle pulse per received byte
o_tx_data  out  8  byte to transmit
o_tx_valid  out  1  byte available
i_tx_ready  in  1  TX accepts byte at posedge when valid&ready
o_halt  out  1  pipeline halt (1 = frozen)
o_write_instruction_mem  out  1  instruction-memory write strobe
o_instruction_mem_addr  out  32  byte address of write
o_instruction_mem_data  out  32  write data
o_r_addr_registers  out  5  register debug read address
o_r_addr_data_mem  out  5  data-memory debug read word index
i_r_data_registers  in  32  register read data
i_r_data_data_mem  in  32  data-memory read data
i_IF_ID / i_ID_EX / i_EX_MEM / i_MEM_WB  in  NB_*  pipeline latch contents
i_end  in  1  pipeline reached HALT

Behaviour:
- Reset (i_reset=0, asynchronous):
  - o_halt=1; o_tx_valid=0; o_tx_data=0.
  - o_write_instruction_mem=0; addr=0; data=0; both read addresses=0.
  - State=IDLE. All counters=0.
- IDLE, command decoding:
  - Only IDLE and LOAD states consume RX bytes. RX bytes arriving in any other state are dropped.
  - 0x4C 'L' -> LOAD_CNT.
  - 0x43 'C' -> RUN.
  - 0x53 'S' -> STEP.
  - Any other byte -> send single 0x15 (NAK), return to IDLE.
- LOAD_CNT: next byte is word count N; 0x00 means 256. Word index k=0 -> LOAD_DATA.
- LOAD_DATA:
  - Assembles 4 bytes big-endian (first byte = bits 31:24).
  - On the 4th byte, next cycle: o_write_instruction_mem=1 for exactly one cycle, addr=4*k, data=word; k++.
  - After word N-1 is written: send 0x06 (ACK), then IDLE.
  - o_halt stays 1 throughout the load.
- RUN:
  - o_halt=0 from the cycle after the command until i_end is sampled high.
  - Then DRAIN: o_halt stays 0 for DRAIN_CYCLES more cycles, then o_halt=1 -> DUMP.
  - i_end already high on entry: DRAIN immediately.
- STEP: o_halt=0 for exactly one cycle, then o_halt=1 -> DUMP.
- DUMP:
  - On entry, snapshot {IF_ID, ID_EX, EX_MEM, MEM_WB}: 350 bits, zero-padded at the LSB end to 352 bits = 44 bytes.
  - Frame order:
    - 0xA5 header;
    - 44 snapshot bytes, MSB first;
    - for r=0..N_REGS-1: 4 bytes of register r, MSB first;
    - for m=0..N_MEM_WORDS-1: 4 bytes of memory word m;
    - 0x5A trailer.
  - Default frame length = 1+44+128+128+1 = 302 bytes.
  - Word fetch: drive the read address, wait one cycle, capture the 32-bit data into a shift register, then send its 4 bytes.
  - Read addresses return to 0 after the dump.
  - Frame complete -> IDLE.
- TX handshake:
  - o_tx_data is stable while o_tx_valid=1 && !i_tx_ready.
  - A byte is consumed at a posedge with valid&ready.
  - The next byte may be presented the following cycle.
  - o_tx_valid never drops without a transfer.
- o_halt is 0 only in RUN, DRAIN and the single STEP cycle.
- Reset mid-operation aborts immediately. A partial load leaves already-written words in place; no further strobe is issued.

Decomposition:
- Shared package:
  - command byte constants ('L','C','S');
  - response constants (ACK 0x06, NAK 0x15, header 0xA5, trailer 0x5A);
  - state encoding;
  - latch width constants (NB_IF_ID, NB_ID_EX, NB_EX_MEM, NB_MEM_WB).
- One sub-module: dump_serializer. Given a start pulse and the snapshot, it sequences read addresses and emits the frame bytes over the TX handshake. The top FSM handles commands, load and run/step.

Test Plan:
1. Hold i_reset=0 mid-cycle -> o_halt=1, o_tx_valid=0, o_write_instruction_mem=0 immediately, without waiting for a clock edge.
2. RX 4C,02,20,A6,00,04,FF,FF,FF,FF -> exactly two write pulses: (addr 0, data 0x20A60004), (addr 4, data 0xFFFFFFFF); then TX 0x06; o_halt=1 throughout.
3. RX 'S' with register model r=0x100+r and memory model m=0x200+m -> o_halt low exactly 1 cycle; 302 TX bytes: first 0xA5; bytes 46..49 = 00,00,01,00; last 0x5A.
4. RX 'C', i_end rises 10 cycles later -> o_halt low until exactly 3 cycles after i_end is sampled, then dump frame of 302 bytes.
5. i_tx_ready low for 5 cycles mid-dump -> o_tx_data/o_tx_valid stable; frame content and count (302) unchanged; RX 'C' during dump is ignored.
6. RX 'X' -> single TX byte 0x15, state IDLE. RX 'L',01,AA,BB, then reset -> no write strobe, no ACK.
